// File: rtl/serp_pixel_writer_if.sv
// Serpentine pixel writer bus.
// Groups the frame control (start/size/status), the upstream pixel stream
// (valid/ready/data/claimed coordinates) and the frame buffer write port
// (en/addr/data/ack).
//   slave  : the pixel writer itself
//   master : whatever drives the writer (scanner + frame buffer side)
interface serp_pixel_writer_if #(
    parameter int X_MAX  = 5,
    parameter int Y_MAX  = 5,
    parameter int DATA_W = 8
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int AW = $clog2(X_MAX * Y_MAX);

    // frame control and status
    logic              start;
    logic [XW-1:0]     max_x;
    logic [YW-1:0]     max_y;
    logic              busy;
    logic              done;
    logic              pos_err;

    // upstream pixel stream
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [XW-1:0]     in_x;
    logic [YW-1:0]     in_y;

    // frame buffer write port
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport slave (
        input  start, max_x, max_y, in_valid, in_data, in_x, in_y, wr_ack,
        output busy, done, pos_err, in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output start, max_x, max_y, in_valid, in_data, in_x, in_y, wr_ack,
        input  busy, done, pos_err, in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/serp_pixel_writer.sv
// Serpentine pixel writer.
// Accepts a pixel stream in serpentine order (even rows left-to-right, odd
// rows right-to-left), tracks the expected position itself, converts it to a
// raster address (y*width + x) and writes each pixel to the frame buffer via
// a write/ack handshake. Upstream-claimed coordinates are only compared
// against the tracked position; a mismatch sets a sticky pos_err.
// Ports:
//   clk    : clock
//   n_rst  : asynchronous reset, active-low
//   bus    : serp_pixel_writer_if.slave (control, pixel stream, write port)
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | waiting for start
//   S_RECV  | in_ready high, waiting for a pixel beat
//   S_WRITE | wr_en high, holding addr/data until wr_ack
//   S_DONE  | one-cycle done pulse, then back to idle
module serp_pixel_writer #(
    parameter int X_MAX  = 5,
    parameter int Y_MAX  = 5,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic n_rst,
    serp_pixel_writer_if.slave bus
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int AW = $clog2(X_MAX * Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [XW-1:0]     r_exp_x;
    logic [YW-1:0]     r_exp_y;
    logic [XW-1:0]     r_max_x;
    logic [YW-1:0]     r_max_y;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [AW-1:0]     r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_pos_err;

    logic [2*AW-1:0]   w_prod;
    logic              w_last_col;
    logic              w_row_end;
    logic              w_last_row;

    // Product formed at double width so a wide y*width never wraps before
    // the final truncation to the address width.
    assign w_prod     = ((2*AW)'(r_exp_y) * (2*AW)'(r_max_x)) + (2*AW)'(r_exp_x);
    // r_max_x/r_max_y are non-zero whenever these are used (zero sizes skip
    // straight to S_DONE), so the -1 never underflows in practice.
    assign w_last_col = (r_exp_x == r_max_x - XW'(1));
    assign w_row_end  = r_exp_y[0] ? (r_exp_x == '0) : w_last_col;
    assign w_last_row = (r_exp_y == r_max_y - YW'(1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_exp_x    <= '0;
            r_exp_y    <= '0;
            r_max_x    <= '0;
            r_max_y    <= '0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pos_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_max_x   <= bus.max_x;
                        r_max_y   <= bus.max_y;
                        r_exp_x   <= '0;
                        r_exp_y   <= '0;
                        r_pos_err <= 1'b0;
                        r_busy    <= 1'b1;
                        if (bus.max_x == '0 || bus.max_y == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RECV;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_RECV: begin
                    if (bus.in_valid) begin
                        r_wr_data  <= bus.in_data;
                        r_wr_addr  <= w_prod[AW-1:0];
                        if (bus.in_x != r_exp_x || bus.in_y != r_exp_y)
                            r_pos_err <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_wr_en    <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (bus.wr_ack) begin
                        r_wr_en <= 1'b0;
                        // Row end steps down a row with x held; otherwise x
                        // moves in the direction of the current row.
                        if (w_row_end)
                            r_exp_y <= r_exp_y + YW'(1);
                        else if (r_exp_y[0])
                            r_exp_x <= r_exp_x - XW'(1);
                        else
                            r_exp_x <= r_exp_x + XW'(1);

                        if (w_row_end && w_last_row) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RECV;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_wr_en    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pos_err  = r_pos_err;
endmodule

// File: tb/tb_serp_pixel_writer.sv
// Testbench for serp_pixel_writer: directed frames from the test plan plus
// randomized frames, all checked against a serpentine/raster model built
// from plain loops over the frame size.
module tb_serp_pixel_writer;
    localparam int X_MAX  = 5;
    localparam int Y_MAX  = 5;
    localparam int DATA_W = 8;
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int AW = $clog2(X_MAX * Y_MAX);

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    serp_pixel_writer_if #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .DATA_W(DATA_W)) bus ();

    serp_pixel_writer #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: visit order for a w x h frame, as raster addresses and coords.
    task automatic build_order(input int w, input int h,
                               output int ax[$], output int ay[$], output int aa[$]);
        ax = {}; ay = {}; aa = {};
        for (int y = 0; y < h; y++)
            for (int k = 0; k < w; k++) begin
                int x;
                x = (y % 2 == 0) ? k : (w - 1 - k);
                ax.push_back(x);
                ay.push_back(y);
                aa.push_back(y * w + x);
            end
    endtask

    task automatic do_start(input int w, input int h);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.max_x = XW'(w);
        bus.max_y = YW'(h);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.max_x = XW'($urandom_range(0, X_MAX));
        bus.max_y = YW'($urandom_range(0, Y_MAX));
        m_err = 1'b0;
        @(negedge clk);
        check("start_pos_err_clr", 32'(bus.pos_err), 0);
        check("start_busy", 32'(bus.busy), 1);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    // One full frame. dly<0 picks a random ack delay (0..3) per pixel.
    // Pixel bad_idx carries claimed coords (bad_x,bad_y); mid_start pulses
    // start with a different size while the second beat is presented.
    task automatic run_frame(input int w, input int h, input int dly,
                             input int bad_idx, input int bad_x, input int bad_y,
                             input bit mid_start);
        int ax[$], ay[$], aa[$];
        bit ok;
        build_order(w, h, ax, ay, aa);
        do_start(w, h);
        for (int i = 0; i < aa.size(); i++) begin
            logic [DATA_W-1:0] d;
            int cx, cy, nd;
            wait_ready(ok);
            if (!ok) return;
            d  = DATA_W'($urandom);
            cx = (i == bad_idx) ? bad_x : ax[i];
            cy = (i == bad_idx) ? bad_y : ay[i];
            if (cx != ax[i] || cy != ay[i]) m_err = 1'b1;
            nd = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_x     = XW'(cx);
            bus.in_y     = YW'(cy);
            if (mid_start && i == 1) begin
                bus.start = 1'b1;
                bus.max_x = XW'(1);
                bus.max_y = YW'(1);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            bus.in_data  = DATA_W'($urandom);
            bus.wr_ack   = (nd == 0);
            @(negedge clk);
            check("wr_en", 32'(bus.wr_en), 1);
            check("wr_addr", 32'(bus.wr_addr), 32'(aa[i]));
            check("wr_data", 32'(bus.wr_data), 32'(d));
            check("ready_low", 32'(bus.in_ready), 0);
            check("pos_err", 32'(bus.pos_err), 32'(m_err));
            for (int k = 0; k < nd; k++) begin
                @(posedge clk); #1;
                if (k == nd - 1) bus.wr_ack = 1'b1;
                @(negedge clk);
                check("hold_wr_en", 32'(bus.wr_en), 1);
                check("hold_addr", 32'(bus.wr_addr), 32'(aa[i]));
                check("hold_data", 32'(bus.wr_data), 32'(d));
                check("hold_ready", 32'(bus.in_ready), 0);
            end
            @(posedge clk); #1;
            bus.wr_ack = 1'b0;
            @(negedge clk);
            check("after_ack_wr_en", 32'(bus.wr_en), 0);
            if (i == aa.size() - 1) begin
                check("done_pulse", 32'(bus.done), 1);
                check("done_pos_err", 32'(bus.pos_err), 32'(m_err));
            end else begin
                check("ready_again", 32'(bus.in_ready), 1);
                check("no_early_done", 32'(bus.done), 0);
            end
        end
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
        check("busy_after_done", 32'(bus.busy), 0);
        check("pos_err_held", 32'(bus.pos_err), 32'(m_err));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int dn, we;
        bus.start = 0; bus.max_x = '0; bus.max_y = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_x = '0; bus.in_y = '0;
        bus.wr_ack = 0;
        m_err = 0;

        #23;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_pos_err", 32'(bus.pos_err), 0);
        @(negedge clk);
        n_rst = 1'b1;

        run_frame(3, 2, 0, -1, 0, 0, 0);   // addresses 0,1,2,5,4,3
        run_frame(3, 2, 3, -1, 0, 0, 0);   // backpressure
        run_frame(2, 2, 0, 2, 0, 1, 0);    // mismatch on (1,1) beat
        run_frame(2, 2, 1, -1, 0, 0, 0);   // next start clears pos_err
        run_frame(1, 1, 0, -1, 0, 0, 0);
        run_frame(1, 3, 1, -1, 0, 0, 0);   // addresses 0,1,2
        run_frame(4, 3, -1, -1, 0, 0, 1);  // start mid-frame ignored

        // zero width: one done pulse, no writes
        @(posedge clk); #1;
        bus.start = 1'b1; bus.max_x = '0; bus.max_y = YW'(3);
        @(posedge clk); #1;
        bus.start = 1'b0;
        dn = 0; we = 0;
        @(negedge clk);
        check("zero_done_first", 32'(bus.done), 1);
        for (int c = 0; c < 4; c++) begin
            if (bus.done) dn++;
            if (bus.wr_en || bus.in_ready) we++;
            @(negedge clk);
        end
        check("zero_done_count", 32'(dn), 1);
        check("zero_no_write", 32'(we), 0);
        check("zero_busy", 32'(bus.busy), 0);

        // reset while in WRITE, with pos_err set beforehand
        do_start(2, 2);
        wait_ready(ok);
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_x = XW'(1); bus.in_y = YW'(1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_wr_en", 32'(bus.wr_en), 1);
        check("pre_rst_pos_err", 32'(bus.pos_err), 1);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(bus.wr_en), 0);
        check("mid_rst_addr", 32'(bus.wr_addr), 0);
        check("mid_rst_data", 32'(bus.wr_data), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_pos_err", 32'(bus.pos_err), 0);
        check("mid_rst_ready", 32'(bus.in_ready), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        @(negedge clk);
        n_rst = 1'b1;
        run_frame(2, 2, 0, -1, 0, 0, 0);   // addresses 0,1,3,2

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            int w, h, bi;
            w  = $urandom_range(1, X_MAX);
            h  = $urandom_range(1, Y_MAX);
            bi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, w * h - 1)) : -1;
            run_frame(w, h, -1, bi, $urandom_range(0, X_MAX - 1),
                      $urandom_range(0, Y_MAX - 1), $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
